// File: rtl/sysid_pkg.sv
`default_nettype none
// ============================================================================
// Package : sysid_pkg
// Brief   : Shared types and constants for the system-ID read master.
// Rev     : 1.0 - initial release
// ============================================================================
package sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ID_CMD  = 3'd1,
    ST_ID_WAIT = 3'd2,
    ST_TS_CMD  = 3'd3,
    ST_TS_WAIT = 3'd4,
    ST_FINISH  = 3'd5
  } sysid_state_e;

  localparam logic        SYSID_ADDR_ID    = 1'b0;
  localparam logic        SYSID_ADDR_TS    = 1'b1;
  localparam logic [31:0] SYSID_DEFAULT_TS = 32'd1489964946;

endpackage
`default_nettype wire

// File: rtl/sysid_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module : sysid_timeout_ctr
// Brief  : Per-transaction cycle counter; expired flags the last allowed cycle.
// Rev    : 1.0 - initial release
// ============================================================================
module sysid_timeout_ctr (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        enable,
  input  logic [15:0] limit,
  output logic        expired
);

  logic [15:0] r_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != 16'hFFFF)) begin
      r_count <= r_count + 16'd1;
    end
  end

  // r_count is the zero-based index of the current cycle, so this cycle is
  // number r_count+1 of the transaction.
  assign expired = enable && (({1'b0, r_count} + 17'd1) >= {1'b0, limit});

endmodule
`default_nettype wire

// File: rtl/sysid_read_master.sv
`default_nettype none
// ============================================================================
// Module : sysid_read_master
// Brief  : Avalon-MM master reading system ID and timestamp, reporting match.
// Rev    : 1.0 - initial release
// ============================================================================
module sysid_read_master
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_DEFAULT_TS,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  sysid_state_e r_state;
  sysid_state_e w_next;
  logic         r_auto_pending;
  logic         w_begin;
  logic         w_cap_id;
  logic         w_cap_ts;
  logic         w_timeout;
  logic         w_expired;
  logic         w_in_txn;
  logic         w_enter_cmd;

  assign w_in_txn    = (r_state == ST_ID_CMD) || (r_state == ST_ID_WAIT) ||
                       (r_state == ST_TS_CMD) || (r_state == ST_TS_WAIT);
  assign w_enter_cmd = (w_next != r_state) &&
                       ((w_next == ST_ID_CMD) || (w_next == ST_TS_CMD));

  sysid_timeout_ctr u_timeout_ctr (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (w_enter_cmd),
    .enable  (w_in_txn),
    .limit   (16'(TIMEOUT_CYCLES)),
    .expired (w_expired)
  );

  // Data arriving in the last allowed cycle wins over the timeout.
  always_comb begin
    w_next    = r_state;
    w_begin   = 1'b0;
    w_cap_id  = 1'b0;
    w_cap_ts  = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start || r_auto_pending) begin
          w_next  = ST_ID_CMD;
          w_begin = 1'b1;
        end
      end
      ST_ID_CMD: begin
        if (!avm_waitrequest && avm_readdatavalid) begin
          w_cap_id = 1'b1;
          w_next   = ST_TS_CMD;
        end else if (w_expired) begin
          w_timeout = 1'b1;
          w_next    = ST_FINISH;
        end else if (!avm_waitrequest) begin
          w_next = ST_ID_WAIT;
        end
      end
      ST_ID_WAIT: begin
        if (avm_readdatavalid) begin
          w_cap_id = 1'b1;
          w_next   = ST_TS_CMD;
        end else if (w_expired) begin
          w_timeout = 1'b1;
          w_next    = ST_FINISH;
        end
      end
      ST_TS_CMD: begin
        if (!avm_waitrequest && avm_readdatavalid) begin
          w_cap_ts = 1'b1;
          w_next   = ST_FINISH;
        end else if (w_expired) begin
          w_timeout = 1'b1;
          w_next    = ST_FINISH;
        end else if (!avm_waitrequest) begin
          w_next = ST_TS_WAIT;
        end
      end
      ST_TS_WAIT: begin
        if (avm_readdatavalid) begin
          w_cap_ts = 1'b1;
          w_next   = ST_FINISH;
        end else if (w_expired) begin
          w_timeout = 1'b1;
          w_next    = ST_FINISH;
        end
      end
      ST_FINISH: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so they line up with it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_auto_pending <= AUTO_START;
      avm_read       <= 1'b0;
      avm_address    <= SYSID_ADDR_ID;
      busy           <= 1'b0;
      done           <= 1'b0;
      id_ok          <= 1'b0;
      ts_ok          <= 1'b0;
      timeout_err    <= 1'b0;
      id_value       <= '0;
      ts_value       <= '0;
    end else begin
      r_state        <= w_next;
      r_auto_pending <= 1'b0;
      avm_read       <= (w_next == ST_ID_CMD) || (w_next == ST_TS_CMD);
      avm_address    <= ((w_next == ST_TS_CMD) || (w_next == ST_TS_WAIT)) ?
                        SYSID_ADDR_TS : SYSID_ADDR_ID;
      busy           <= (w_next != ST_IDLE);
      done           <= (r_state == ST_FINISH);
      if (w_begin) begin
        id_ok       <= 1'b0;
        ts_ok       <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (w_cap_id) begin
        id_value <= avm_readdata;
        id_ok    <= (avm_readdata == EXPECTED_ID);
      end
      if (w_cap_ts) begin
        ts_value <= avm_readdata;
        ts_ok    <= (avm_readdata == EXPECTED_TIMESTAMP);
      end
      if (w_timeout) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sysid_read_master.sv
`default_nettype none
// ============================================================================
// Module : tb_sysid_read_master
// Brief  : Randomised reactive-slave bench for sysid_read_master.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_sysid_read_master;

  localparam int          T      = 8;
  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'd1489964946;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  logic        a_addr, a_read, a_busy, a_done, a_id_ok, a_ts_ok, a_to;
  logic [31:0] a_id_val, a_ts_val;
  logic        b_addr, b_read, b_busy, b_done, b_id_ok, b_ts_ok, b_to;
  logic [31:0] b_id_val, b_ts_val;

  always #5 clock = ~clock;

  sysid_read_master #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS),
    .TIMEOUT_CYCLES(T), .AUTO_START(1'b1)
  ) u_dut_auto (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(a_addr), .avm_read(a_read), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .busy(a_busy), .done(a_done), .id_ok(a_id_ok), .ts_ok(a_ts_ok),
    .timeout_err(a_to), .id_value(a_id_val), .ts_value(a_ts_val)
  );

  // Second instance without auto-start; it shares all inputs and runs in
  // lockstep with the first once both are idle.
  sysid_read_master #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS),
    .TIMEOUT_CYCLES(T), .AUTO_START(1'b0)
  ) u_dut_manual (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(b_addr), .avm_read(b_read), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .busy(b_busy), .done(b_done), .id_ok(b_id_ok), .ts_ok(b_ts_ok),
    .timeout_err(b_to), .id_value(b_id_val), .ts_value(b_ts_val)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Slave configuration: wait states, latency and data per word address.
  int          cfg_w [2];
  int          cfg_l [2];
  logic [31:0] cfg_d [2];
  int          stall_n;
  int          lat_n;
  bit          pend;
  logic        pend_a;
  bit          prev_stall;
  logic        prev_addr;
  int          rd1_cycles;
  bit          stray_en;

  // Reactive slave, driven on the falling edge from the master's outputs.
  initial begin
    avm_waitrequest   = 1'b1;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    forever begin
      @(negedge clock);
      avm_readdatavalid = 1'b0;
      avm_waitrequest   = 1'b1;
      avm_readdata      = $urandom;
      if (!reset_n) begin
        pend = 0; stall_n = 0; prev_stall = 0;
      end else begin
        if (prev_stall) begin
          check_eq("stall_read", 32'(a_read), 32'(stall_n < T));
          if (a_read) check_eq("stall_addr", 32'(a_addr), 32'(prev_addr));
        end
        if (a_read) begin
          if (a_addr) rd1_cycles++;
          if (stall_n < cfg_w[a_addr]) begin
            stall_n++; prev_stall = 1; prev_addr = a_addr;
          end else begin
            avm_waitrequest = 1'b0; stall_n = 0; prev_stall = 0;
            if (cfg_l[a_addr] == 0) begin
              avm_readdatavalid = 1'b1; avm_readdata = cfg_d[a_addr];
            end else begin
              pend = 1; pend_a = a_addr; lat_n = cfg_l[a_addr];
            end
          end
        end else begin
          prev_stall = 0; stall_n = 0;
          if (pend) begin
            lat_n--;
            if (lat_n == 0) begin
              pend = 0; avm_readdatavalid = 1'b1; avm_readdata = cfg_d[pend_a];
            end
          end else if (stray_en && !a_busy && ($urandom_range(0, 3) == 0)) begin
            avm_readdatavalid = 1'b1;
          end
        end
      end
    end
  end

  // Reference model state: last captured words.
  logic [31:0] m_id, m_ts;

  task automatic set_cfg(input int w1, l1, w2, l2, input logic [31:0] d_id, d_ts);
    cfg_w[0] = w1; cfg_l[0] = l1; cfg_d[0] = d_id;
    cfg_w[1] = w2; cfg_l[1] = l2; cfg_d[1] = d_ts;
    pend = 0; rd1_cycles = 0;
  endtask

  // Counts rising edges until done is seen, bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (n < 200) begin
      @(posedge clock); #1;
      n++;
      if (n == 1) start = 1'b0;
      if (a_done) break;
    end
  endtask

  task automatic run_case(input string tag, input int w1, l1, w2, l2,
                          input logic [31:0] d_id, d_ts);
    int n, exp_n;
    bit to_id, to_ts;
    set_cfg(w1, l1, w2, l2, d_id, d_ts);
    // A read lasts wait+latency+1 cycles and must fit within T cycles.
    to_id = (w1 + l1 + 1) > T;
    to_ts = !to_id && ((w2 + l2 + 1) > T);
    if (to_id)      exp_n = T + 2;
    else if (to_ts) exp_n = 3 + w1 + l1 + T;
    else            exp_n = 4 + w1 + l1 + w2 + l2;
    if (!to_id)           m_id = d_id;
    if (!to_id && !to_ts) m_ts = d_ts;
    @(negedge clock); start = 1'b1;
    wait_done(n);
    check_eq({tag, "_latency"}, 32'(n), 32'(exp_n));
    check_eq({tag, "_id_ok"}, 32'(a_id_ok), 32'(!to_id && (d_id == EXP_ID)));
    check_eq({tag, "_ts_ok"}, 32'(a_ts_ok), 32'(!to_id && !to_ts && (d_ts == EXP_TS)));
    check_eq({tag, "_timeout"}, 32'(a_to), 32'(to_id || to_ts));
    check_eq({tag, "_id_value"}, a_id_val, m_id);
    check_eq({tag, "_ts_value"}, a_ts_val, m_ts);
    check_eq({tag, "_ts_read_issued"}, 32'(rd1_cycles != 0), 32'(!to_id));
    @(posedge clock); #1;
    check_eq({tag, "_done_pulse"}, 32'(a_done), 32'd0);
    check_eq({tag, "_busy_after"}, 32'(a_busy), 32'd0);
  endtask

  initial begin
    int n, n_done, w1, l1, w2, l2;
    bit found, b_active;
    logic [31:0] d_id, d_ts;
    start = 1'b0; reset_n = 1'b0; stray_en = 0;
    stall_n = 0; lat_n = 0; pend = 0; pend_a = 0; prev_stall = 0; prev_addr = 0;
    rd1_cycles = 0; m_id = '0; m_ts = '0;
    set_cfg(0, 0, 0, 0, EXP_ID, EXP_TS);
    repeat (3) @(negedge clock);
    #1;
    check_eq("rst_read", 32'(a_read), 0);
    check_eq("rst_addr", 32'(a_addr), 0);
    check_eq("rst_busy", 32'(a_busy), 0);
    check_eq("rst_done", 32'(a_done), 0);
    check_eq("rst_flags", {29'd0, a_id_ok, a_ts_ok, a_to}, 0);
    check_eq("rst_id_value", a_id_val, 0);
    check_eq("rst_ts_value", a_ts_val, 0);

    // Auto-start against a zero-wait, zero-latency slave.
    @(negedge clock); reset_n = 1'b1;
    wait_done(n);
    m_id = EXP_ID; m_ts = EXP_TS;
    check_eq("auto_latency", 32'(n), 32'd4);
    check_eq("auto_flags", {29'd0, a_id_ok, a_ts_ok, a_to}, 32'b110);
    check_eq("manual_not_started", 32'(b_busy | b_done | b_read), 0);

    // Directed cases from the plan, then randomised ones.
    run_case("bad_id", 0, 0, 0, 0, 32'h5, EXP_TS);
    run_case("wait_lat", 3, 2, 3, 2, EXP_ID, EXP_TS);
    run_case("stuck_wait", 1000, 0, 0, 0, EXP_ID, EXP_TS);
    run_case("ts_timeout", 1, 1, 0, 9, EXP_ID, EXP_TS);
    stray_en = 1;
    for (int i = 0; i < 25; i++) begin
      w1 = $urandom_range(0, 4); l1 = $urandom_range(0, 4);
      w2 = $urandom_range(0, 4); l2 = $urandom_range(0, 4);
      case ($urandom_range(0, 7))
        0: w1 = 9;
        1: l1 = 9;
        2: w2 = 9;
        3: l2 = 9;
        default: ;
      endcase
      d_id = $urandom_range(0, 1) ? EXP_ID : $urandom;
      d_ts = $urandom_range(0, 1) ? EXP_TS : $urandom;
      run_case("rand", w1, l1, w2, l2, d_id, d_ts);
    end
    stray_en = 0;

    // Start pulsed while busy must not produce a second check.
    set_cfg(2, 2, 2, 2, EXP_ID, EXP_TS);
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (3) @(negedge clock);
    start = 1'b1;
    @(negedge clock); start = 1'b0;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (a_done) n_done++;
    end
    check_eq("busy_start_dones", 32'(n_done), 32'd1);
    check_eq("busy_start_flags", {29'd0, a_id_ok, a_ts_ok, a_to}, 32'b110);

    // Reset while waiting on the timestamp read.
    set_cfg(0, 0, 0, 6, EXP_ID, EXP_TS);
    @(negedge clock); start = 1'b1;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      start = 1'b0;
      if (a_busy && a_addr && !a_read) begin
        found = 1;
        break;
      end
    end
    check_eq("ts_wait_reached", 32'(found), 32'd1);
    check_eq("pre_reset_id_ok", 32'(a_id_ok), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("async_rst_read", 32'(a_read), 0);
    check_eq("async_rst_busy", 32'(a_busy | b_busy), 0);
    check_eq("async_rst_flags", {29'd0, a_id_ok, a_ts_ok, a_to}, 0);
    check_eq("async_rst_id_value", a_id_val, 0);
    set_cfg(0, 0, 0, 0, EXP_ID, EXP_TS);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    b_active = 0; n_done = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clock); #1;
      b_active = b_active | b_busy | b_read | b_done;
      if (a_done) n_done++;
    end
    m_id = EXP_ID; m_ts = EXP_TS;
    check_eq("manual_stays_idle", 32'(b_active), 0);
    check_eq("auto_restart_dones", 32'(n_done), 32'd1);

    d_id = $urandom | 32'h1;
    run_case("after_reset", 0, 1, 1, 0, d_id, EXP_TS);
    check_eq("manual_id_value", b_id_val, d_id);
    check_eq("manual_flags", {29'd0, b_id_ok, b_ts_ok, b_to}, 32'b010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/sysid_read_master.md
# sysid_read_master

Avalon-MM read master that queries the system-ID slave: reads word 0 (system ID) and word 1 (build timestamp), compares each against expected parameters, and reports pass/fail. It sits on the Qsys interconnect alongside the Nios II as an independent boot-time integrity check. It also provides a re-triggerable check for software or a debug pin. It handles wait-states and variable read latency, and applies a per-transaction timeout.

## Interface
- `EXPECTED_ID`, default 0: expected word at address 0.
- `EXPECTED_TIMESTAMP`, default 1489964946: expected word at address 1.
- `TIMEOUT_CYCLES`, default 255: maximum cycles per read transaction, measured from `avm_read` assertion to `avm_readdatavalid`. Range 1..65535.
- `AUTO_START`, default 1: when 1, start one check automatically after reset is released.

- `clock`  in  1  single clock domain.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  level-sampled request to begin a check; ignored while `busy`.
- `avm_address`  out  1  word address: 0 = ID, 1 = timestamp.
- `avm_read`  out  1  read request.
- `avm_waitrequest`  in  1  slave stall.
- `avm_readdata`  in  32  read data.
- `avm_readdatavalid`  in  1  read data qualifier.
- `busy`  out  1  check in progress.
- `done`  out  1  one-cycle pulse at the end of a check.
- `id_ok`  out  1  latched result: ID matched.
- `ts_ok`  out  1  latched result: timestamp matched.
- `timeout_err`  out  1  latched result: a transaction timed out.
- `id_value`  out  32  last ID read.
- `ts_value`  out  32  last timestamp read.

## Operation
- States: IDLE, ID_CMD, ID_WAIT, TS_CMD, TS_WAIT, FINISH.
- IDLE:
  - On `start`=1, or on the first cycle after reset if `AUTO_START`=1, go to ID_CMD.
  - On entry from IDLE, clear `id_ok`, `ts_ok` and `timeout_err`.
- ID_CMD:
  - Drive `avm_read`=1 and `avm_address`=0.
  - Hold both while `avm_waitrequest`=1.
  - The command is accepted on the cycle where `avm_waitrequest`=0; then go to ID_WAIT.
  - If `avm_readdatavalid`=1 in that same acceptance cycle (zero-latency slave), capture the data and go directly to TS_CMD.
- ID_WAIT:
  - `avm_read`=0.
  - On `avm_readdatavalid`=1: load `id_value` from `avm_readdata`, set `id_ok` = (data == `EXPECTED_ID`), go to TS_CMD.
- TS_CMD and TS_WAIT: same behaviour with address 1. Capture into `ts_value` and `ts_ok`, then go to FINISH.
- FINISH: pulse `done` for one cycle, then go to IDLE.
- Timeout:
  - A 16-bit counter clears on entry to each \*_CMD state and increments every cycle in \*_CMD and \*_WAIT.
  - When the count reaches `TIMEOUT_CYCLES` before data arrives: drop `avm_read`, set `timeout_err`=1, leave the current ok flag at 0, go to FINISH. The remaining read is skipped.
- Stray `avm_readdatavalid` in IDLE, \*_CMD or FINISH is ignored, except in the acceptance cycle described under ID_CMD.
- Comparison is a full 32-bit equality; no masking.

## Timing
- Reset values:
  - `avm_read`, `avm_address`, `busy`, `done`, `id_ok`, `ts_ok`, `timeout_err`: 0.
  - `id_value`, `ts_value`: 0.
  - State: IDLE.
- All outputs are registered.
- `busy`=1 from the cycle after the start is sampled until the FINISH cycle inclusive.
- Against a zero-wait, zero-latency slave (`readdatavalid` concurrent with accept), start to `done` is 4 cycles: ID_CMD, TS_CMD, FINISH, then `done` visible.
- Each wait-state cycle adds 1 cycle; each cycle of read latency adds 1 cycle.
- `start` held high re-triggers a new check immediately after FINISH.
- Reset mid-check aborts immediately: `avm_read` drops asynchronously and all flags clear.
- Because of the aborted read, the interconnect must also be in reset. The block does not drain outstanding reads.

## Structure
- Shared package `sysid_pkg` holds:
  - the state enum;
  - the address constants `SYSID_ADDR_ID`=0 and `SYSID_ADDR_TS`=1;
  - the default timestamp constant.
- One sub-module: `sysid_timeout_ctr` (clear, enable, limit → `expired`).
- FSM and capture registers live in the top level.

## Test plan
- Reset released, `AUTO_START`=1, slave returns 0 / 1489964946 with zero wait and zero latency:
  - `done` pulses 4 cycles after reset release;
  - `id_ok`=1, `ts_ok`=1, `timeout_err`=0.
- Slave returns ID 0x00000005:
  - `id_ok`=0, `ts_ok`=1, `id_value`=5.
- `avm_waitrequest` held for 3 cycles, then data 2 cycles after accept:
  - `avm_read` and `avm_address` stay stable during the stall;
  - `done` arrives 10 cycles later than in the zero-wait case (5 extra cycles per read);
  - both ok flags = 1.
- `TIMEOUT_CYCLES`=8 and `avm_waitrequest` stuck at 1:
  - `avm_read` drops after 8 cycles;
  - `timeout_err`=1, `id_ok`=0, `ts_ok`=0;
  - no address-1 read is issued.
- `reset_n` asserted during TS_WAIT:
  - same cycle: `avm_read`=0 and all flags 0;
  - after release with `AUTO_START`=0, the block stays IDLE until `start`=1.
- `start` pulsed during `busy`: ignored, exactly one `done` pulse.
